fpu_mul_arbiter: RTL and testbench
==================================

FPU_MUL_ARBITER -- requirements
Module: fpu_mul_arbiter

Interface
REQ-001 Parameter FRACW, default 10, stored-fraction width; operands are FRACW+1 bits (hidden bit included) and products are 2*FRACW+2 bits.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0Valid, req1Valid  input  1 each  requester n has an operand pair pending.
REQ-005 req0A, req0B, req1A, req1B  input  FRACW+1 each  requester mantissa operands.
REQ-006 req0Ready, req1Ready  output  1 each  grant/accept strobe; handshake completes when Valid and Ready are both high.
REQ-007 respValid  output  1  product available.
REQ-008 respReady  input  1  consumer accepts the product.
REQ-009 respId  output  1  index of the requester that owns respProd.
REQ-010 respProd  output  2*FRACW+2  unsigned product.
REQ-011 mulIn1, mulIn2  output  FRACW+1 each  operands to the shared sequential multiplier.
REQ-012 mulStart  output  1  one-cycle start pulse to the multiplier.
REQ-013 mulReset  output  1  multiplier reset, registered (glitch-free).
REQ-014 mulOut  input  2*FRACW+2  multiplier product.
REQ-015 mulDone  input  1  multiplier completion level, held until multiplier reset.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, CLR, START, WAIT, RESP; all outputs are registered or decoded from state and registers only, except req0Ready and req1Ready.
REQ-018 IDLE: if any reqNValid is high, the block SHALL assert Ready combinationally to exactly one winner, latch its A, B and id, and go to CLR, or to RESP when the zero fast path applies.
REQ-019 Arbitration SHALL be round-robin: pointer rrPtr (reset 0) names the preferred requester; the other requester wins only when the preferred one is not valid.
REQ-020 rrPtr SHALL be set to the inverse of the winning id on every accepted request; a lone requester may therefore win back-to-back.
REQ-021 Zero fast path: if the latched A or B is 0, the block SHALL bypass the multiplier, load respProd=0 and go directly to RESP (respValid on the cycle after accept).
REQ-022 CLR: mulReset=1 for exactly one cycle, then go to START.
REQ-023 START: mulStart=1 for exactly one cycle, then go to WAIT; mulIn1/mulIn2 SHALL carry the latched operands from START through WAIT.
REQ-024 WAIT: on the first cycle mulDone=1, the block SHALL capture mulOut into respProd and go to RESP; there is no timeout.
REQ-025 RESP: respValid=1, and respId and respProd SHALL be held stable until respReady=1; on that cycle go to IDLE.
REQ-026 No request SHALL be accepted in any state other than IDLE, and reqNReady=0 outside IDLE.
REQ-027 Minimum non-bypass turnaround: the block SHALL accept, spend 1 cycle in CLR, 1 in START, then WAIT plus multiplier latency, then 1 or more cycles in RESP.
REQ-028 A new accept SHALL be possible on the cycle after the RESP handshake.
REQ-029 Requester operand changes after accept SHALL NOT affect the in-flight product.
REQ-030 mulIn1/mulIn2 SHALL be 0 in IDLE.

Reset
REQ-031 While reset is high, the block SHALL hold state=IDLE, rrPtr=0, respValid=0, respId=0, respProd=0, mulStart=0, mulIn1=mulIn2=0, busy=0, and Ready=0.
REQ-032 mulReset SHALL be 1 while reset is high and SHALL fall on the first clock edge after reset deasserts.
REQ-033 Reset mid-operation (any state) SHALL abandon the transaction, with no respValid afterwards for it.

Verification
REQ-034 Single op: req0 A=0x400, B=0x400 -> req0Ready pulse, mulReset then mulStart each 1 cycle, respValid with respId=0 and respProd=0x100000.
REQ-035 Max operands: req1 A=0x7FF, B=0x7FF -> respProd=0x3FF001, respId=1.
REQ-036 Contention: both valid continuously from reset -> grants alternate 0,1,0,1, and each product matches its owner.
REQ-037 Zero bypass: req0 A=0, B=0x5A5 -> respValid the next cycle with respProd=0, and mulStart and mulReset never pulse.
REQ-038 Backpressure: respReady held 0 for 5 cycles in RESP -> respProd/respId stable, no Ready asserted; accept resumes the cycle after respReady=1.
REQ-039 Reset in WAIT -> all outputs at reset values, mulReset=1, and a later fresh request completes correctly.

Source files
------------

// File: rtl/fpu_mul_arbiter.sv
// fpu_mul_arbiter
// Shares one sequential mantissa multiplier between two requesters. A
// round-robin grant is issued in IDLE, the winner's operands are latched, the
// multiplier is cleared (CLR), started (START) and waited on (WAIT). The
// product is then presented on the response port until it is taken (RESP).
// Operands of zero skip the multiplier and go straight to RESP with a zero
// product.
//
// Ports
//   clock, reset            rising-edge clock, async active-high reset
//   req0Valid/req1Valid     requester has an operand pair pending
//   req0A/B, req1A/B        requester mantissas, FRACW+1 bits (hidden bit incl.)
//   req0Ready/req1Ready     combinational grant; handshake on Valid & Ready
//   respValid/respReady     product handshake toward the consumer
//   respId                  requester that owns respProd
//   respProd                unsigned product, 2*FRACW+2 bits
//   mulIn1/mulIn2           operands to the shared multiplier
//   mulStart                one-cycle start pulse to the multiplier
//   mulReset                registered multiplier reset
//   mulOut/mulDone          multiplier product and completion level
//   busy                    high in every state except IDLE
module fpu_mul_arbiter #(
  parameter int unsigned FRACW = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0Valid,
  input  logic                 req1Valid,
  input  logic [FRACW:0]       req0A,
  input  logic [FRACW:0]       req0B,
  input  logic [FRACW:0]       req1A,
  input  logic [FRACW:0]       req1B,
  output logic                 req0Ready,
  output logic                 req1Ready,
  output logic                 respValid,
  input  logic                 respReady,
  output logic                 respId,
  output logic [2*FRACW+1:0]   respProd,
  output logic [FRACW:0]       mulIn1,
  output logic [FRACW:0]       mulIn2,
  output logic                 mulStart,
  output logic                 mulReset,
  input  logic [2*FRACW+1:0]   mulOut,
  input  logic                 mulDone,
  output logic                 busy
);

  localparam int unsigned OPW   = FRACW + 1;
  localparam int unsigned PRODW = 2 * FRACW + 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t             r_state;
  logic               r_rrPtr;
  logic [OPW-1:0]     r_a;
  logic [OPW-1:0]     r_b;
  logic               r_id;
  logic [PRODW-1:0]   r_prod;
  logic               r_mulReset;

  logic               w_idle;
  logic               w_grant0;
  logic               w_grant1;
  logic               w_accept;
  logic               w_winId;
  logic [OPW-1:0]     w_winA;
  logic [OPW-1:0]     w_winB;
  logic               w_zero;

  // Grant logic: reset is folded in so no Ready escapes while reset is held.
  assign w_idle   = (r_state == IDLE) && !reset;
  assign w_grant0 = w_idle && req0Valid && (!r_rrPtr || !req1Valid);
  assign w_grant1 = w_idle && req1Valid && ( r_rrPtr || !req0Valid);
  assign w_accept = w_grant0 || w_grant1;
  assign w_winId  = w_grant1;
  assign w_winA   = w_grant1 ? req1A : req0A;
  assign w_winB   = w_grant1 ? req1B : req0B;
  assign w_zero   = (w_winA == '0) || (w_winB == '0);

  assign req0Ready = w_grant0;
  assign req1Ready = w_grant1;

  // Control FSM with operand/result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rrPtr    <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_id       <= 1'b0;
      r_prod     <= '0;
      r_mulReset <= 1'b1;
    end else begin
      r_mulReset <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= w_winA;
            r_b     <= w_winB;
            r_id    <= w_winId;
            r_rrPtr <= ~w_winId;
            if (w_zero) begin
              r_prod  <= '0;
              r_state <= RESP;
            end else begin
              // Raised on the edge into CLR so the pulse covers exactly CLR.
              r_mulReset <= 1'b1;
              r_state    <= CLR;
            end
          end
        end
        CLR:   r_state <= START;
        START: r_state <= WAIT;
        WAIT: begin
          if (mulDone) begin
            r_prod  <= mulOut;
            r_state <= RESP;
          end
        end
        RESP: begin
          if (respReady) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs decoded from state and registers only.
  assign respValid = (r_state == RESP);
  assign respId    = r_id;
  assign respProd  = r_prod;
  assign mulStart  = (r_state == START);
  assign mulReset  = r_mulReset;
  assign busy      = (r_state != IDLE);
  assign mulIn1    = ((r_state == START) || (r_state == WAIT)) ? r_a : '0;
  assign mulIn2    = ((r_state == START) || (r_state == WAIT)) ? r_b : '0;

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// tb_fpu_mul_arbiter
// Directed scenarios plus randomized traffic against a transaction-level
// reference: arbitration by preferred-requester rule, products by plain
// multiplication, and a behavioural sequential multiplier with random latency.
module tb_fpu_mul_arbiter;

  localparam int unsigned FRACW = 10;
  localparam int unsigned OPW   = FRACW + 1;
  localparam int unsigned PRODW = 2 * FRACW + 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             req0Valid, req1Valid;
  logic [OPW-1:0]   req0A, req0B, req1A, req1B;
  logic             req0Ready, req1Ready;
  logic             respValid, respReady, respId;
  logic [PRODW-1:0] respProd;
  logic [OPW-1:0]   mulIn1, mulIn2;
  logic             mulStart, mulReset, busy;
  logic [PRODW-1:0] mulOut = '0;
  logic             mulDone = 1'b0;

  always #5 clock = ~clock;

  fpu_mul_arbiter #(.FRACW(FRACW)) dut (
    .clock(clock), .reset(reset),
    .req0Valid(req0Valid), .req1Valid(req1Valid),
    .req0A(req0A), .req0B(req0B), .req1A(req1A), .req1B(req1B),
    .req0Ready(req0Ready), .req1Ready(req1Ready),
    .respValid(respValid), .respReady(respReady),
    .respId(respId), .respProd(respProd),
    .mulIn1(mulIn1), .mulIn2(mulIn2),
    .mulStart(mulStart), .mulReset(mulReset),
    .mulOut(mulOut), .mulDone(mulDone), .busy(busy)
  );

  // Behavioural sequential multiplier: done level after mul_lat cycles,
  // cleared only by mulReset; output is junk until done.
  int             mul_lat = 3;
  int             m_cnt = 0;
  logic           m_run = 1'b0;
  logic [OPW-1:0] m_a = '0, m_b = '0;

  always @(posedge clock) begin
    if (mulReset) begin
      mulDone <= 1'b0;
      m_run   <= 1'b0;
      mulOut  <= PRODW'($urandom);
    end else if (mulStart) begin
      m_a   <= mulIn1;
      m_b   <= mulIn2;
      m_cnt <= mul_lat;
      m_run <= 1'b1;
    end else if (m_run) begin
      if (m_cnt <= 1) begin
        mulDone <= 1'b1;
        mulOut  <= PRODW'(m_a) * PRODW'(m_b);
        m_run   <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  typedef struct packed {
    logic             id;
    logic             zero;
    logic [OPW-1:0]   a;
    logic [OPW-1:0]   b;
    logic [PRODW-1:0] prod;
  } txn_t;

  txn_t             q[$];
  int               grants[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  logic             mdl_ptr = 1'b0;
  logic             mdl_busy = 1'b0;
  int               age = 0;
  int               got_acc = -1;
  logic             last_id = 1'b0;
  logic [PRODW-1:0] last_prod = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compares one sampled cycle with the reference and advances it.
  task automatic monitor();
    logic [1:0] exp_g;
    logic       was_busy;
    logic       anyv;
    txn_t       t;
    txn_t       n;
    got_acc = -1;
    if (reset) return;
    anyv     = req0Valid || req1Valid;
    was_busy = mdl_busy;
    exp_g    = 2'b00;
    if (anyv && !was_busy) begin
      if (mdl_ptr == 1'b0) exp_g = req0Valid ? 2'b01 : 2'b10;
      else                 exp_g = req1Valid ? 2'b10 : 2'b01;
    end
    check("grant", 32'({req1Ready, req0Ready}), 32'(exp_g));
    check("busy", 32'(busy), 32'(was_busy));
    if (!was_busy) begin
      check("mulin_idle", 32'({mulIn1, mulIn2}), 32'd0);
      check("resp_spurious", 32'(respValid), 32'd0);
    end else begin
      t = q[0];
      if (t.zero) begin
        check("zero_no_mul", 32'({mulReset, mulStart}), 32'd0);
        if (age == 1) check("zero_latency", 32'(respValid), 32'd1);
      end else if (age == 1) begin
        check("clr_pulse", 32'({respValid, mulReset, mulStart}), 32'b010);
      end else if (age == 2) begin
        check("start_pulse", 32'({respValid, mulReset, mulStart}), 32'b001);
        check("start_ops", 32'({mulIn1, mulIn2}), 32'({t.a, t.b}));
      end else begin
        check("no_repulse", 32'({mulReset, mulStart}), 32'd0);
        if (!respValid) check("wait_ops", 32'({mulIn1, mulIn2}), 32'({t.a, t.b}));
      end
      if (respValid) begin
        check("resp_id", 32'(respId), 32'(t.id));
        check("resp_prod", 32'(respProd), 32'(t.prod));
        if (respReady) begin
          last_id   = respId;
          last_prod = respProd;
          void'(q.pop_front());
          mdl_busy  = 1'b0;
        end
      end
    end
    if (exp_g != 2'b00) begin
      n.id   = exp_g[1];
      n.a    = n.id ? req1A : req0A;
      n.b    = n.id ? req1B : req0B;
      n.zero = (n.a == 0) || (n.b == 0);
      n.prod = PRODW'(n.a) * PRODW'(n.b);
      q.push_back(n);
      grants.push_back(int'(n.id));
      mdl_ptr  = ~n.id;
      mdl_busy = 1'b1;
      age      = 0;
      got_acc  = int'(n.id);
    end
    if (mdl_busy) age++;
  endtask

  task automatic clk_step();
    #1;
    monitor();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string tag, input int bound);
    int n = 0;
    while (mdl_busy && n < bound) begin
      clk_step();
      n++;
    end
    check(tag, 32'(mdl_busy), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_ready", 32'({req1Ready, req0Ready}), 32'd0);
    check("rst_flags", 32'({respValid, respId, mulStart, busy}), 32'd0);
    check("rst_prod", 32'(respProd), 32'd0);
    check("rst_mulin", 32'({mulIn1, mulIn2}), 32'd0);
    check("rst_mulreset", 32'(mulReset), 32'd1);
    repeat (2) @(posedge clock);
    #1;
    reset    = 1'b0;
    q.delete();
    grants.delete();
    mdl_busy = 1'b0;
    mdl_ptr  = 1'b0;
    age      = 0;
  endtask

  function automatic logic [OPW-1:0] rand_op();
    int unsigned r = $urandom_range(0, 11);
    if (r == 0) return '0;
    if (r == 1) return '1;
    return OPW'($urandom);
  endfunction

  task automatic single(input logic id, input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    if (id) begin req1Valid = 1'b1; req1A = a; req1B = b; end
    else    begin req0Valid = 1'b1; req0A = a; req0B = b; end
    clk_step();
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    req0A = rand_op(); req0B = rand_op(); req1A = rand_op(); req1B = rand_op();
  endtask

  initial begin
    int n;
    req0Valid = 1'b0; req1Valid = 1'b0; respReady = 1'b1;
    req0A = '0; req0B = '0; req1A = '0; req1B = '0;
    do_reset();
    clk_step();
    check("rst_release_mulreset", 32'(mulReset), 32'd0);

    // Single op through the multiplier.
    mul_lat = 3;
    single(1'b0, 11'h400, 11'h400);
    drain("t_single_done", 40);
    check("t_single_prod", 32'(last_prod), 32'h100000);
    check("t_single_id", 32'(last_id), 32'd0);

    // Largest operands from requester 1.
    single(1'b1, 11'h7FF, 11'h7FF);
    drain("t_max_done", 40);
    check("t_max_prod", 32'(last_prod), 32'h3FF001);
    check("t_max_id", 32'(last_id), 32'd1);

    // Zero bypass.
    single(1'b0, 11'h000, 11'h5A5);
    check("t_zero_resp_next", 32'(respValid), 32'd1);
    drain("t_zero_done", 10);
    check("t_zero_prod", 32'(last_prod), 32'd0);

    // Backpressure: hold the response while both requesters wait.
    respReady = 1'b0;
    single(1'b1, 11'h6A3, 11'h4F1);
    n = 0;
    while (!respValid && n < 30) begin clk_step(); n++; end
    check("t_bp_resp", 32'(respValid), 32'd1);
    req0Valid = 1'b1; req0A = 11'h500; req0B = 11'h433;
    req1Valid = 1'b1; req1A = 11'h777; req1B = 11'h123;
    repeat (5) clk_step();
    check("t_bp_still_valid", 32'(respValid), 32'd1);
    respReady = 1'b1;
    clk_step();
    clk_step();
    check("t_bp_resume", 32'(got_acc), 32'd0);
    req0Valid = 1'b0;
    drain("t_bp_done", 40);
    check("t_bp_prod", 32'(last_prod), 32'(PRODW'(11'h500) * PRODW'(11'h433)));
    single(1'b1, req1A, req1B);
    drain("t_bp_done2", 40);

    // Reset while the multiplier is running.
    mul_lat = 6;
    single(1'b0, 11'h555, 11'h0C3);
    repeat (3) clk_step();
    check("t_rst_in_wait_busy", 32'(busy), 32'd1);
    do_reset();
    repeat (8) clk_step();
    mul_lat = 2;
    single(1'b1, 11'h555, 11'h003);
    drain("t_rst_fresh_done", 40);
    check("t_rst_fresh_prod", 32'(last_prod), 32'hFFF);
    check("t_rst_fresh_id", 32'(last_id), 32'd1);

    // Contention from reset: both requesters always valid.
    req0Valid = 1'b1; req0A = rand_op(); req0B = rand_op();
    req1Valid = 1'b1; req1A = rand_op(); req1B = rand_op();
    do_reset();
    n = 0;
    while (grants.size() < 6 && n < 300) begin
      mul_lat = $urandom_range(1, 5);
      clk_step();
      if (got_acc == 0) begin req0A = rand_op(); req0B = rand_op(); end
      if (got_acc == 1) begin req1A = rand_op(); req1B = rand_op(); end
      n++;
    end
    check("t_cont_count", 32'(grants.size() >= 6), 32'd1);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      check("t_cont_order", 32'(grants[i]), 32'(i % 2));
    req0Valid = 1'b0; req1Valid = 1'b0;
    drain("t_cont_done", 40);

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      if (!req0Valid && $urandom_range(0, 3) == 0) begin
        req0Valid = 1'b1; req0A = rand_op(); req0B = rand_op();
      end
      if (!req1Valid && $urandom_range(0, 3) == 0) begin
        req1Valid = 1'b1; req1A = rand_op(); req1B = rand_op();
      end
      respReady = ($urandom_range(0, 2) != 0);
      if (!mdl_busy) mul_lat = $urandom_range(1, 6);
      clk_step();
      if (got_acc == 0) begin req0Valid = 1'b0; req0A = rand_op(); req0B = rand_op(); end
      if (got_acc == 1) begin req1Valid = 1'b0; req1A = rand_op(); req1B = rand_op(); end
    end
    req0Valid = 1'b0; req1Valid = 1'b0; respReady = 1'b1;
    drain("t_rand_done", 60);
    check("t_rand_queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
